// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR load/run interface.
//   - fir_state_e : load sequencer state encoding (3 bits)
//   - FIR_DW, FIR_NTAPS, FIR_NSAMP : default word width and frame sizes
//     shared with FIR_Top
//   - FIR_RUN_CYCLES, FIR_CW : default run length and counter width
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_C = 3'd1,
    LOAD_X = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } fir_state_e;

  localparam int FIR_DW         = 16;
  localparam int FIR_NTAPS      = 64;
  localparam int FIR_NSAMP      = 64;
  localparam int FIR_RUN_CYCLES = 64;
  localparam int FIR_CW         = 8;

endpackage

// File: rtl/fir_seq_counter.sv
// fir_seq_counter: loadable up-counter with terminal-count compare.
// Ports:
//   clk   in  1   rising-edge clock
//   rst   in  1   synchronous active-high reset
//   clear in  1   force the count to zero (wins over en)
//   en    in  1   advance the count by one
//   limit in  CW  number of counts in one pass
//   tc    out 1   en is high and this is the last count of the pass;
//                 the counter wraps to zero on that edge
module fir_seq_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          tc
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = en && (cnt_q == (limit - ONE));

  // Next count: clear, wrap on terminal count, or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      if (tc) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fir_load_sequencer.sv
// fir_load_sequencer: drives the FIR core load/run interface.
// One upstream valid/ready stream carries NTAPS coefficients followed by
// NSAMP samples; coefficients go out on cin/cload, samples on xin/wr_en
// (with xload framing the sample phase), then rd_en is held for RUN_CYCLES
// cycles and a one-cycle done pulse ends the frame.
// Ports:
//   clk_10khz in 1, rst in 1 (sync, active high), start in 1, abort in 1
//   in_data in DW, in_valid in 1, in_ready out 1 (combinational from state)
//   cload out 1, cin out DW, xload out 1, wr_en out 1, xin out DW
//   rd_en out 1, busy out 1, done out 1
//   csum out DW+8 (only with FIR_LOAD_CSUM_EN): running sum of the
//   coefficients accepted in the current frame
// Optional feature macro: FIR_LOAD_CSUM_EN
module fir_load_sequencer
  import fir_pkg::*;
#(
  parameter int DW         = FIR_DW,
  parameter int NTAPS      = FIR_NTAPS,
  parameter int NSAMP      = FIR_NSAMP,
  parameter int RUN_CYCLES = FIR_RUN_CYCLES,
  parameter int CW         = FIR_CW
) (
  input  logic          clk_10khz,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          cload,
  output logic [DW-1:0] cin,
  output logic          xload,
  output logic          wr_en,
  output logic [DW-1:0] xin,
  output logic          rd_en,
  output logic          busy,
`ifdef FIR_LOAD_CSUM_EN
  output logic [DW+7:0] csum,
`endif
  output logic          done
);

  fir_state_e    state_q, state_d;
  logic          cload_q, cload_d;
  logic [DW-1:0] cin_q, cin_d;
  logic          xload_q, xload_d;
  logic          wr_en_q, wr_en_d;
  logic [DW-1:0] xin_q, xin_d;
  logic          rd_en_q, rd_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept;
  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_tc;
  logic [CW-1:0] cnt_limit;

  assign in_ready = (state_q == LOAD_C) || (state_q == LOAD_X);
  assign accept   = in_valid && in_ready;

  // One counter serves all three phases; its pass length follows the state.
  always_comb begin
    cnt_limit = '0;
    case (state_q)
      LOAD_C:  cnt_limit = CW'(NTAPS);
      LOAD_X:  cnt_limit = CW'(NSAMP);
      RUN:     cnt_limit = CW'(RUN_CYCLES);
      default: cnt_limit = '0;
    endcase
  end

  fir_seq_counter #(.CW(CW)) u_cnt (
    .clk   (clk_10khz),
    .rst   (rst),
    .clear (cnt_clr),
    .en    (cnt_en),
    .limit (cnt_limit),
    .tc    (cnt_tc)
  );

  // Next state, counter control and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    cload_d = 1'b0;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    done_d  = 1'b0;
    cin_d   = cin_q;
    xin_d   = xin_q;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (start) begin
          state_d = LOAD_C;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_C: begin
        cnt_en = accept;
        if (accept) begin
          cload_d = 1'b1;
          cin_d   = in_data;
          if (cnt_tc) begin
            state_d = LOAD_X;
          end else begin
            state_d = LOAD_C;
          end
        end else begin
          state_d = LOAD_C;
        end
      end
      LOAD_X: begin
        cnt_en = accept;
        if (accept) begin
          wr_en_d = 1'b1;
          xin_d   = in_data;
          if (cnt_tc) begin
            state_d = RUN;
          end else begin
            state_d = LOAD_X;
          end
        end else begin
          state_d = LOAD_X;
        end
      end
      RUN: begin
        cnt_en  = 1'b1;
        rd_en_d = 1'b1;
        if (cnt_tc) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        cnt_clr = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
    // abort overrides everything: a beat taken this cycle is dropped unwritten.
    if (abort) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
      cload_d = 1'b0;
      wr_en_d = 1'b0;
      rd_en_d = 1'b0;
      done_d  = 1'b0;
      cin_d   = cin_q;
      xin_d   = xin_q;
    end else begin
      state_d = state_d;
    end
    // xload follows the state being entered so it falls on the same edge
    // that raises wr_en for the last sample.
    xload_d = (state_d == LOAD_X);
    busy_d  = (state_q != IDLE) && !abort;
  end

  // State and registered outputs.
  always_ff @(posedge clk_10khz) begin
    if (rst) begin
      state_q <= IDLE;
      cload_q <= 1'b0;
      cin_q   <= '0;
      xload_q <= 1'b0;
      wr_en_q <= 1'b0;
      xin_q   <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cload_q <= cload_d;
      cin_q   <= cin_d;
      xload_q <= xload_d;
      wr_en_q <= wr_en_d;
      xin_q   <= xin_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cload = cload_q;
  assign cin   = cin_q;
  assign xload = xload_q;
  assign wr_en = wr_en_q;
  assign xin   = xin_q;
  assign rd_en = rd_en_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef FIR_LOAD_CSUM_EN
  logic [DW+7:0] csum_q, csum_d;

  // Coefficient checksum: cleared by an honoured start, grows per written coefficient.
  always_comb begin
    csum_d = csum_q;
    if ((state_q == IDLE) && start && !abort) begin
      csum_d = '0;
    end else if ((state_q == LOAD_C) && accept && !abort) begin
      csum_d = csum_q + {8'd0, in_data};
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk_10khz) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_fir_load_sequencer.sv
// Scoreboard bench for fir_load_sequencer (NTAPS=NSAMP=RUN_CYCLES=4).
// Cycle n of a frame is the cycle following the (n-1)-th rising edge after
// the edge that samples start (edge 0). Expected high cycles per strobe,
// expected cin/xin words and spot values are queued before each frame; the
// negedge monitor pops and compares whenever the DUT raises an output.
module tb_fir_load_sequencer;

  logic        clk_10khz = 1'b0;
  logic        rst, start, abort, in_valid;
  logic [15:0] in_data;
  logic        in_ready, cload, xload, wr_en, rd_en, busy, done;
  logic [15:0] cin, xin;
`ifdef FIR_LOAD_CSUM_EN
  logic [23:0] csum;
`endif

  always #5 clk_10khz = ~clk_10khz;

  fir_load_sequencer #(.DW(16), .NTAPS(4), .NSAMP(4), .RUN_CYCLES(4), .CW(8)) dut (
    .clk_10khz (clk_10khz),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cload     (cload),
    .cin       (cin),
    .xload     (xload),
    .wr_en     (wr_en),
    .xin       (xin),
    .rd_en     (rd_en),
    .busy      (busy),
`ifdef FIR_LOAD_CSUM_EN
    .csum      (csum),
`endif
    .done      (done)
  );

  typedef struct { int cyc; int sel; logic [31:0] val; } hold_t;

  int          checks = 0;
  int          errors = 0;
  int          ec = 0;
  int          base = -1000;
  int          qh[7][$];
  logic [15:0] qc[$];
  logic [15:0] qx[$];
  hold_t       qhold[$];
  string       nm[7] = '{"in_ready", "cload", "wr_en", "xload", "rd_en", "busy", "done"};
  logic        st[32];
  logic        ab[32];
  logic        vl[32];
  logic [15:0] dt[32];

  always @(posedge clk_10khz) ec <= ec + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every high strobe must match the next queued cycle.
  always @(negedge clk_10khz) begin : mon
    int          rel;
    int          e;
    logic [6:0]  sv;
    logic [31:0] act;
    hold_t       h;
    rel = ec - base + 1;
    sv  = {done, busy, rd_en, xload, wr_en, cload, in_ready};
    for (int s = 0; s < 7; s++) begin
      if (sv[s] === 1'b1) begin
        checks++;
        if (qh[s].size() == 0) begin
          errors++;
          $display("FAIL %s unexpected high at cycle %0d: actual 1 required 0", nm[s], rel);
        end else begin
          e = qh[s].pop_front();
          if (e != rel) begin
            errors++;
            $display("FAIL %s timing: actual cycle %0d required cycle %0d", nm[s], rel, e);
          end
        end
      end
    end
    if (cload === 1'b1 && qc.size() > 0) chk("cin_word", {16'd0, cin}, {16'd0, qc.pop_front()});
    if (wr_en === 1'b1 && qx.size() > 0) chk("xin_word", {16'd0, xin}, {16'd0, qx.pop_front()});
    while (qhold.size() > 0 && qhold[0].cyc == rel) begin
      h = qhold.pop_front();
      case (h.sel)
        0: act = {16'd0, cin};
        1: act = {16'd0, xin};
`ifdef FIR_LOAD_CSUM_EN
        2: act = {8'd0, csum};
`endif
        default: act = 32'hFFFF_FFFF;
      endcase
      chk($sformatf("hold_sel%0d_cycle%0d", h.sel, h.cyc), act, h.val);
    end
  end

  task automatic new_frame();
    base = -1000;
    for (int k = 0; k < 32; k++) begin
      st[k] = 1'b0; ab[k] = 1'b0; vl[k] = 1'b0; dt[k] = 16'd0;
    end
  endtask

  task automatic hi(input int s, input int a, input int b);
    for (int c = a; c <= b; c++) qh[s].push_back(c);
  endtask

  task automatic hold(input int cyc, input int sel, input logic [31:0] v);
    hold_t h;
    h.cyc = cyc; h.sel = sel; h.val = v;
    qhold.push_back(h);
  endtask

  task automatic set_ideal(input int w);
    st[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      vl[k] = 1'b1;
      dt[k] = 16'(w + k - 1);
    end
  endtask

  // Ideal-upstream frame: coefficients cycles 2-5, samples 6-9, run 10-13, done 14.
  task automatic exp_ideal();
    hi(0, 1, 8); hi(1, 2, 5); hi(2, 6, 9); hi(3, 5, 8);
    hi(4, 10, 13); hi(5, 2, 14); hi(6, 14, 14);
    for (int k = 1; k <= 4; k++) qc.push_back(dt[k]);
    for (int k = 5; k <= 8; k++) qx.push_back(dt[k]);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      start = st[k]; abort = ab[k]; in_valid = vl[k]; in_data = dt[k];
      @(posedge clk_10khz);
      #1;
      if (k == 0) base = ec;
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = 16'd0;
    repeat (3) @(posedge clk_10khz);
    @(negedge clk_10khz);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_cload", {31'd0, cload}, 32'd0);
    chk("rst_cin", {16'd0, cin}, 32'd0);
    chk("rst_xload", {31'd0, xload}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_xin", {16'd0, xin}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
`ifdef FIR_LOAD_CSUM_EN
    chk("rst_csum", {8'd0, csum}, 32'd0);
`endif
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk_10khz);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk_10khz);
    #1;

    // Full frame, words 1..8.
    new_frame(); set_ideal(1); exp_ideal(); run(17);

    // Backpressure on coefficients, start during RUN and DONE.
    new_frame();
    st[0] = 1'b1; st[13] = 1'b1; st[16] = 1'b1;
    vl[1] = 1'b1; dt[1] = 16'd11;
    dt[2] = 16'hDEAD;
    vl[3] = 1'b1; dt[3] = 16'd12;
    dt[4] = 16'hDEAD;
    vl[5] = 1'b1; dt[5] = 16'd13;
    dt[6] = 16'hDEAD;
    vl[7] = 1'b1; dt[7] = 16'd14;
    for (int k = 8; k <= 11; k++) begin
      vl[k] = 1'b1; dt[k] = 16'(21 + k - 8);
    end
    hi(0, 1, 11); hi(1, 2, 2); hi(1, 4, 4); hi(1, 6, 6); hi(1, 8, 8);
    hi(2, 9, 12); hi(3, 8, 11); hi(4, 13, 16); hi(5, 2, 17); hi(6, 17, 17);
    for (int k = 11; k <= 14; k++) qc.push_back(16'(k));
    for (int k = 21; k <= 24; k++) qx.push_back(16'(k));
    hold(3, 0, 32'd11); hold(5, 0, 32'd12); hold(7, 0, 32'd13); hold(13, 1, 32'd24);
    run(19);

    // Abort together with the second coefficient beat.
    new_frame();
    st[0] = 1'b1;
    vl[1] = 1'b1; dt[1] = 16'd31;
    vl[2] = 1'b1; dt[2] = 16'd32; ab[2] = 1'b1;
    hi(0, 1, 2); hi(1, 2, 2); hi(5, 2, 2);
    qc.push_back(16'd31);
    hold(3, 0, 32'd31); hold(4, 0, 32'd31);
    run(6);

    // Fresh frame reloads from the first coefficient.
    new_frame(); set_ideal(41); exp_ideal(); run(17);

    // start and abort together in IDLE: nothing happens.
    new_frame();
    st[0] = 1'b1; ab[0] = 1'b1;
    hold(2, 0, 32'd44); hold(3, 1, 32'd48);
    run(5);

`ifdef FIR_LOAD_CSUM_EN
    // Checksum of four all-ones coefficients.
    new_frame(); set_ideal(51);
    for (int k = 1; k <= 4; k++) dt[k] = 16'hFFFF;
    exp_ideal();
    hold(1, 2, 32'd0); hold(3, 2, 32'h0001_FFFE); hold(6, 2, 32'h0003_FFFC);
    hold(16, 2, 32'h0003_FFFC);
    run(17);

    // Next start clears it; an aborted beat is not added.
    new_frame();
    st[0] = 1'b1; vl[1] = 1'b1; dt[1] = 16'd5; ab[1] = 1'b1;
    hi(0, 1, 1);
    hold(1, 2, 32'd0); hold(2, 2, 32'd0);
    run(3);
`endif

    repeat (2) @(negedge clk_10khz);
    for (int s = 0; s < 7; s++) chk({nm[s], "_missing"}, qh[s].size(), 32'd0);
    chk("cin_missing", qc.size(), 32'd0);
    chk("xin_missing", qx.size(), 32'd0);
    chk("hold_missing", qhold.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
